instr_fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer for the pipelined RISC-V core. Owns the fetch PC and drives the

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_skid_fifo.sv | 72 +++++++
 rtl/instr_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch block
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
// ---------------------------------------------------------------------------
// fetch_skid_fifo : small {pc, instr} FIFO between ROM and decode; flush wins
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     last_head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_r;

  assign count = count_r;
  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_W'(DEPTH));
  // When empty the head keeps showing the last entry presented to decode.
  assign head  = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      last_head <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      last_head <= head;
    end else begin
      last_head <= head;
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl : fetch PC sequencer, ROM address drive and decode handshake
//                    optional PC bounds check under ROM_BOUNDS_CHECK_EN
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] INSTRUCTION_ADDRESS,
  input  logic [DATA_W-1:0] INSTRUCTION,
  input  logic              REDIRECT,
  input  logic [31:0]       REDIRECT_PC,
  input  logic              HALT,
  output logic              IF_VALID,
  input  logic              IF_READY,
  output logic [31:0]       IF_PC,
  output logic [DATA_W-1:0] IF_INSTR
`ifdef ROM_BOUNDS_CHECK_EN
  ,
  output logic              FETCH_FAULT
`endif
);

  fetch_state_t                 state;
  fetch_state_t                 state_nxt;
  logic [31:0]                  fpc;
  logic                         pop;
  logic                         push;
  logic                         push_cand;
  logic                         pc_illegal;
  logic                         buf_full;
  logic                         buf_empty;
  logic [$clog2(BUF_DEPTH):0]   buf_count_unused;
  fetch_entry_t                 wr_entry;
  fetch_entry_t                 head;

  assign INSTRUCTION_ADDRESS = fpc[ADDR_W+1:2];
  assign IF_VALID            = !buf_empty && !REDIRECT;
  assign pop                 = IF_VALID && IF_READY;
  assign push_cand           = (state == RUN) && !HALT && !REDIRECT && (!buf_full || pop);

`ifdef ROM_BOUNDS_CHECK_EN
  assign pc_illegal  = (fpc[31:ADDR_W+2] != '0) || (fpc[1:0] != 2'b00);
  assign FETCH_FAULT = (state == FAULT);
`else
  assign pc_illegal  = 1'b0;
`endif

  assign push     = push_cand && !pc_illegal;
  assign wr_entry = '{pc: fpc, instr: 32'(INSTRUCTION)};
  assign IF_PC    = head.pc;
  assign IF_INSTR = head.instr[DATA_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (HALT) begin
          state_nxt = HOLD;
        end else if (push_cand && pc_illegal) begin
          state_nxt = FAULT;
        end
      end
      HOLD: begin
        if (!HALT) begin
          state_nxt = RUN;
        end
      end
      FAULT: begin
        if (REDIRECT) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // A redirect always reloads fpc, even while held or faulted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      fpc   <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (REDIRECT) begin
        fpc <= REDIRECT_PC;
      end else if (push) begin
        fpc <= fpc + PC_STEP;
      end
    end
  end

  fetch_skid_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (CLK),
    .rst     (RESET),
    .push    (push),
    .pop     (pop),
    .flush   (REDIRECT),
    .wr_data (wr_entry),
    .head    (head),
    .count   (buf_count_unused),
    .full    (buf_full),
    .empty   (buf_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_ctrl : directed + random stimulus, queue scoreboard vs stream model
// Revision            : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_ctrl;

  localparam int          ADDR_W = 10;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              REDIRECT = 1'b0;
  logic [31:0]       REDIRECT_PC = 32'h0;
  logic              HALT = 1'b0;
  logic              IF_READY = 1'b0;
  logic [ADDR_W-1:0] INSTRUCTION_ADDRESS;
  logic [DATA_W-1:0] INSTRUCTION;
  logic              IF_VALID;
  logic [31:0]       IF_PC;
  logic [DATA_W-1:0] IF_INSTR;
`ifdef ROM_BOUNDS_CHECK_EN
  logic              FETCH_FAULT;
`endif

  logic [DATA_W-1:0] golden [1 << ADDR_W];
  assign INSTRUCTION = golden[INSTRUCTION_ADDRESS];

  always #5 CLK = ~CLK;

  instr_fetch_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .INSTRUCTION_ADDRESS (INSTRUCTION_ADDRESS),
    .INSTRUCTION         (INSTRUCTION),
    .REDIRECT            (REDIRECT),
    .REDIRECT_PC         (REDIRECT_PC),
    .HALT                (HALT),
    .IF_VALID            (IF_VALID),
    .IF_READY            (IF_READY),
    .IF_PC               (IF_PC),
    .IF_INSTR            (IF_INSTR)
`ifdef ROM_BOUNDS_CHECK_EN
    ,
    .FETCH_FAULT         (FETCH_FAULT)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          passes = 0;
  int          pops   = 0;
  bit          armed  = 1'b0;

  // Reference model: occupancy count, fetch pointer, mode (0 run, 1 hold, 2 fault)
  int          m_count = 0;
  logic [31:0] m_fpc   = RST_PC;
  int          m_mode  = 0;
  bit          m_pop, m_cand, m_legal;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      m_count = 0;
      m_fpc   = RST_PC;
      m_mode  = 0;
      armed   = 1'b1;
    end else begin
      m_pop   = (m_count > 0) && !REDIRECT && IF_READY;
      m_cand  = (m_mode == 0) && !HALT && !REDIRECT && ((m_count < DEPTH) || m_pop);
      m_legal = 1'b1;
`ifdef ROM_BOUNDS_CHECK_EN
      m_legal = ((m_fpc >> (ADDR_W + 2)) == 0) && ((m_fpc % 4) == 0);
`endif
      if (REDIRECT) begin
        exp_q.delete();
        m_count = 0;
        m_fpc   = REDIRECT_PC;
      end else begin
        if (m_pop) m_count--;
        if (m_cand && m_legal) begin
          exp_q.push_back('{pc: m_fpc, instr: golden[m_fpc[ADDR_W+1:2]]});
          m_count++;
          m_fpc = m_fpc + 32'd4;
        end
      end
      case (m_mode)
        0: if (HALT) m_mode = 1; else if (m_cand && !m_legal) m_mode = 2;
        1: if (!HALT) m_mode = 0;
        default: if (REDIRECT) m_mode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      check("if_valid", 32'(IF_VALID), 32'((m_count != 0) && !REDIRECT));
      check("rom_addr", 32'(INSTRUCTION_ADDRESS), 32'(m_fpc[ADDR_W+1:2]));
`ifdef ROM_BOUNDS_CHECK_EN
      check("fetch_fault", 32'(FETCH_FAULT), 32'(m_mode == 2));
`endif
      if (IF_VALID && IF_READY) begin
        if (exp_q.size() == 0) begin
          check("pop_with_empty_scoreboard", 32'(IF_PC), 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("if_pc", IF_PC, e.pc);
          check("if_instr", IF_INSTR, e.instr);
          pops++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] w;
    for (int i = 0; i < (1 << ADDR_W); i++) golden[i] = $urandom;

    RESET = 1'b1; IF_READY = 1'b1;
    tick(2);
    check("rst_if_valid", 32'(IF_VALID), 32'h0);
    check("rst_if_pc", IF_PC, 32'h0);
    check("rst_if_instr", IF_INSTR, 32'h0);
    RESET = 1'b0;
    tick(8);

    IF_READY = 1'b0; tick(5);
    IF_READY = 1'b1; tick(6);

    IF_READY = 1'b0; tick(3);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h40; tick(1);
    REDIRECT = 1'b0; IF_READY = 1'b1; tick(6);

    HALT = 1'b1; tick(3);
    HALT = 1'b0; tick(6);

    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFC; tick(1);
    REDIRECT = 1'b0; tick(6);
`ifdef ROM_BOUNDS_CHECK_EN
    check("fault_set", 32'(FETCH_FAULT), 32'h1);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h0; tick(1);
    REDIRECT = 1'b0; tick(1);
    check("fault_clear", 32'(FETCH_FAULT), 32'h0);
    tick(5);
`endif

    IF_READY = 1'b0; tick(3);
    RESET = 1'b1; tick(1);
    check("midrst_if_valid", 32'(IF_VALID), 32'h0);
    check("midrst_if_pc", IF_PC, 32'h0);
    RESET = 1'b0; IF_READY = 1'b1; tick(4);

    repeat (800) begin
      IF_READY = ($urandom_range(0, 3) != 0);
      HALT     = ($urandom_range(0, 9) == 0);
      REDIRECT = ($urandom_range(0, 19) == 0);
      w        = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      REDIRECT_PC = ($urandom_range(0, 7) == 0) ? $urandom : {20'h0, w, 2'b00};
      RESET    = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    RESET = 1'b0; REDIRECT = 1'b0; HALT = 1'b0; IF_READY = 1'b1;
    tick(6);
    check("stream_progress", 32'(pops > 300), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
